pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Next-PC controller for the single-cycle core; drives the ProgramCounter's `PCin` each cycle.
- Combines current `PCAddress`, decoder/ALU redirect requests, stall, trap and debug-halt into one next address.
- Holds machine state for control flow: EPC, cause, a pending-redirect latch, a boot-hold counter and the run/halt FSM.
- Sits between the control unit / branch comparator and ProgramCounter.

Parameters:
- `RESET_VECTOR`, 32'h0000_0000, address issued during reset and boot hold.
- `TRAP_VECTOR`, 32'h0000_0100, target for exceptions.
- `BOOT_CYCLES`, 4, cycles PC is held at `RESET_VECTOR` after reset release (0 = none).

Ports:
- `CLK`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PCAddress`  in  32  current PC from ProgramCounter.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  32  PC+immB.
- `jal`  in  1  JAL instruction.
- `jal_target`  in  32  PC+immJ.
- `jalr`  in  1  JALR instruction.
- `jalr_target`  in  32  rs1+immI, unmasked.
- `mret`  in  1  return from trap.
- `ecall`  in  1  environment-call exception.
- `ebreak`  in  1  enter debug halt.
- `resume`  in  1  leave halt (single-cycle pulse).
- `stall`  in  1  hold PC this cycle.
- `PCin`  out  32  next PC, combinational, to ProgramCounter.
- `epc`  out  32  saved exception PC.
- `mcause`  out  4  trap cause: 0 = misaligned fetch, 11 = ecall.
- `halted`  out  1  FSM in HALT.
- `redirect`  out  1  `PCin` ≠ `PCAddress`+4 while in RUN.

Behaviour:
- Reset is asynchronous and active-high. On `reset`:
  - state=BOOT, boot counter=`BOOT_CYCLES`, `epc`=0, `mcause`=0, pending latch cleared.
  - `PCin`=`RESET_VECTOR`, `halted`=0, `redirect`=0.
- States: BOOT, RUN, STALL, HALT.
- BOOT:
  - `PCin`=`RESET_VECTOR`; counter decrements each clock.
  - At 0 → RUN.
  - With `BOOT_CYCLES`=0, the first clock after reset release enters RUN.
  - All requests are ignored in BOOT.
- RUN target priority (highest first), used as `PCin`:
  - `ecall` → `TRAP_VECTOR`; `epc`<=`PCAddress`; `mcause`<=11.
  - `ebreak` → `PCin`=`PCAddress`; next state HALT.
  - `mret` → `epc`.
  - `jalr` → `jalr_target` & ~32'h1.
  - `jal` → `jal_target`.
  - `branch_taken` → `branch_target`.
  - Otherwise → `PCAddress`+4, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Misaligned fetch:
  - Applies when the selected redirect target has bits [1:0]≠0 (after the JALR mask).
  - `PCin`=`TRAP_VECTOR`; `epc`<=`PCAddress`; `mcause`<=0.
- `stall`=1 in RUN:
  - `PCin`=`PCAddress`; next state STALL.
  - A redirect (mret/jalr/jal/branch, misaligned check applied) asserted that cycle is latched as pending target.
  - `ecall` during stall is ignored; the control unit re-presents it.
- STALL:
  - `PCin`=`PCAddress` while `stall`=1.
  - On the first cycle with `stall`=0: `PCin`=pending target if valid, else RUN rules apply. Pending is cleared; next state RUN.
  - New redirects in STALL overwrite pending only if none is pending (first wins).
- HALT:
  - `PCin`=`PCAddress`, `halted`=1.
  - `resume` → `PCin`=`PCAddress`+4; next state RUN.
  - Other requests are ignored.
- `epc` and `mcause` update only on a trap; they otherwise hold.
- `reset` mid-operation (any state) immediately forces the reset values above; pending is discarded.
- Latency: zero-cycle combinational `PCin`. The PC register update occurs at the next `CLK` edge.

Test Plan:
- `reset` pulse, `BOOT_CYCLES`=4, `PCAddress`=0 → `PCin`=0 for 4 clocks, then 4, 8, 12 on successive clocks.
- RUN, `PCAddress`=0x20, `branch_taken`=1, `branch_target`=0x40, `jal`=1, `jal_target`=0x80 → `PCin`=0x80, `redirect`=1.
- `jalr`=1, `jalr_target`=0x103 → masked 0x102 is misaligned → `PCin`=0x100, `epc`=0x20, `mcause`=0. Then `mret` → `PCin`=0x20.
- `stall`=1 for 3 cycles at `PCAddress`=0x30 with `branch_taken`=1, target 0x60, asserted in cycle 1 → `PCin`=0x30 for 3 cycles, then 0x60.
- `ebreak` at 0x44 → `halted`=1, `PCin`=0x44 for 5 cycles with `jal` toggling; `resume` → `PCin`=0x48, `halted`=0.
- `reset` asserted mid-STALL with pending 0x60 → `PCin`=`RESET_VECTOR` asynchronously; after boot, sequential fetch resumes; 0x60 is never issued.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the single-cycle core: boot hold, redirect priority,
// traps, stall-time pending redirect and debug halt. PCin is purely combinational.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          BOOT_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] PCAddress,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jal,
  input  logic [31:0] jal_target,
  input  logic        jalr,
  input  logic [31:0] jalr_target,
  input  logic        mret,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        resume,
  input  logic        stall,
  output logic [31:0] PCin,
  output logic [31:0] epc,
  output logic [3:0]  mcause,
  output logic        halted,
  output logic        redirect
);
  localparam int CW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;
  state_t state, state_nx;

  logic [CW-1:0] boot_cnt;
  logic          pend_vld, pend_mis;
  logic [31:0]   pend_tgt;
  logic [31:0]   seq_pc, redir_tgt, run_pc;
  logic          redir_req, redir_mis, run_trap, run_halt;
  logic [3:0]    run_cause, trap_cause;
  logic          trap_en, pend_load, release_stall;

  assign seq_pc        = PCAddress + 32'd4;
  assign release_stall = (state == STALL) && !stall;
  // Only the first redirect seen while stalled is kept.
  assign pend_load     = stall && redir_req &&
                         ((state == RUN) || ((state == STALL) && !pend_vld));

  // Redirect target selection (mret > jalr > jal > branch) with alignment check.
  always_comb begin
    redir_req = mret | jalr | jal | branch_taken;
    redir_tgt = seq_pc;
    if (mret)              redir_tgt = epc;
    else if (jalr)         redir_tgt = jalr_target & ~32'h1;
    else if (jal)          redir_tgt = jal_target;
    else if (branch_taken) redir_tgt = branch_target;
    redir_mis = redir_req && (redir_tgt[1:0] != 2'b00);
  end

  // Unstalled RUN decision, shared by RUN and a STALL release with nothing pending.
  always_comb begin
    run_pc    = seq_pc;
    run_trap  = 1'b0;
    run_cause = 4'd0;
    run_halt  = 1'b0;
    if (ecall) begin
      run_pc    = TRAP_VECTOR;
      run_trap  = 1'b1;
      run_cause = 4'd11;
    end else if (ebreak) begin
      run_pc   = PCAddress;
      run_halt = 1'b1;
    end else if (redir_mis) begin
      run_pc   = TRAP_VECTOR;
      run_trap = 1'b1;
    end else if (redir_req) begin
      run_pc = redir_tgt;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      boot_cnt <= CW'(BOOT_CYCLES);
      epc      <= 32'd0;
      mcause   <= 4'd0;
      pend_vld <= 1'b0;
      pend_mis <= 1'b0;
      pend_tgt <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == BOOT && boot_cnt != '0) boot_cnt <= boot_cnt - 1'b1;
      if (trap_en) begin
        epc    <= PCAddress;
        mcause <= trap_cause;
      end
      if (release_stall) begin
        pend_vld <= 1'b0;
        pend_mis <= 1'b0;
      end else if (pend_load) begin
        pend_vld <= 1'b1;
        pend_mis <= redir_mis;
        pend_tgt <= redir_mis ? TRAP_VECTOR : redir_tgt;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:  if (boot_cnt <= CW'(1)) state_nx = RUN;
      RUN:   if (stall) state_nx = STALL;
             else if (run_halt) state_nx = HALT;
      STALL: if (!stall) state_nx = (!pend_vld && run_halt) ? HALT : RUN;
      HALT:  if (resume) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  always_comb begin
    PCin       = PCAddress;
    trap_en    = 1'b0;
    trap_cause = run_cause;
    case (state)
      BOOT: PCin = RESET_VECTOR;
      RUN: if (!stall) begin
        PCin    = run_pc;
        trap_en = run_trap;
      end
      STALL: if (!stall) begin
        if (pend_vld) begin
          PCin       = pend_tgt;
          trap_en    = pend_mis;
          trap_cause = 4'd0;
        end else begin
          PCin    = run_pc;
          trap_en = run_trap;
        end
      end
      HALT: if (resume) PCin = seq_pc;
      default: PCin = RESET_VECTOR;
    endcase
  end

  assign halted   = (state == HALT);
  assign redirect = (state == RUN) && (PCin != seq_pc);
endmodule
